// File: rtl/rib_master_arb.sv
// rtl/rib_master_arb.sv - round-robin merge of up to eight RIB masters onto one master port
// Tracks a single outstanding transaction and routes its response back to the winning master.
module rib_master_arb #(
  parameter int masters = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [32*masters-1:0]  i_ribm_addr,
  input  logic [masters-1:0]     i_ribm_wrcs,
  input  logic [4*masters-1:0]   i_ribm_mask,
  input  logic [32*masters-1:0]  i_ribm_wdata,
  output logic [32*masters-1:0]  o_ribm_rdata,
  input  logic [masters-1:0]     i_ribm_req,
  output logic [masters-1:0]     o_ribm_gnt,
  output logic [masters-1:0]     o_ribm_rsp,
  input  logic [masters-1:0]     i_ribm_rdy,
  output logic [31:0]            o_rib_addr,
  output logic                   o_rib_wrcs,
  output logic [3:0]             o_rib_mask,
  output logic [31:0]            o_rib_wdata,
  input  logic [31:0]            i_rib_rdata,
  output logic                   o_rib_req,
  input  logic                   i_rib_gnt,
  input  logic                   i_rib_rsp,
  output logic                   o_rib_rdy
);

  logic [2:0] rr_ptr, lock_id, owner_id;
  logic       lock, pending;
  logic [2:0] search_id, sel_id, next_ptr;
  logic [3:0] idx;
  logic [7:0] req_ext, rdy_ext;
  logic       sel_valid, owner_rdy, complete, bus_free, hs;

  // Zero-extend to eight so 3-bit IDs index safely for any master count.
  always_comb begin
    req_ext = '0;
    rdy_ext = '0;
    req_ext[masters-1:0] = i_ribm_req;
    rdy_ext[masters-1:0] = i_ribm_rdy;
  end

  // Walk from the far end back toward rr_ptr so the nearest requester wins.
  always_comb begin
    search_id = '0;
    idx       = '0;
    for (int i = masters - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + 4'(i);
      if (idx >= 4'(masters)) idx = idx - 4'(masters);
      if (req_ext[idx[2:0]]) search_id = idx[2:0];
    end
  end

  assign sel_id    = lock ? lock_id : search_id;
  assign sel_valid = |i_ribm_req;
  assign owner_rdy = rdy_ext[owner_id];
  assign complete  = pending & i_rib_rsp & owner_rdy;
  assign bus_free  = ~pending | complete;
  assign o_rib_req = sel_valid & bus_free & ~i_rst;
  assign hs        = o_rib_req & i_rib_gnt;
  assign o_rib_rdy = pending & owner_rdy & ~i_rst;
  assign next_ptr  = (sel_id == 3'(masters - 1)) ? 3'd0 : sel_id + 3'd1;

  assign o_ribm_rdata = {masters{i_rib_rdata}};

  always_comb begin
    o_rib_addr  = '0;
    o_rib_wrcs  = 1'b0;
    o_rib_mask  = '0;
    o_rib_wdata = '0;
    o_ribm_gnt  = '0;
    o_ribm_rsp  = '0;
    for (int k = 0; k < masters; k++) begin
      if (sel_id == 3'(k)) begin
        o_rib_addr  = i_ribm_addr[32*k +: 32];
        o_rib_wrcs  = i_ribm_wrcs[k];
        o_rib_mask  = i_ribm_mask[4*k +: 4];
        o_rib_wdata = i_ribm_wdata[32*k +: 32];
      end
      o_ribm_gnt[k] = hs & (sel_id == 3'(k));
      o_ribm_rsp[k] = pending & i_rib_rsp & ~i_rst & (owner_id == 3'(k));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_id  <= '0;
      pending  <= 1'b0;
      owner_id <= '0;
    end else if (hs) begin
      // A completing and a new handshake in one cycle hand ownership straight over.
      lock     <= 1'b0;
      pending  <= 1'b1;
      owner_id <= sel_id;
      rr_ptr   <= next_ptr;
    end else begin
      if (o_rib_req) begin
        lock    <= 1'b1;
        lock_id <= sel_id;
      end
      if (complete) pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rib_master_arb.sv
// tb/tb_rib_master_arb.sv - self-checking bench for rib_master_arb
// Directed scenarios plus a randomized run against a transaction-level reference model.
module tb_rib_master_arb;
  localparam int M = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [32*M-1:0] addr, wdata;
  logic [M-1:0]  wrcs, req, rdy;
  logic [4*M-1:0] mask;
  logic [32*M-1:0] ribm_rdata;
  logic [M-1:0]  ribm_gnt, ribm_rsp;
  logic [31:0]   rib_addr, rib_wdata, rdata;
  logic          rib_wrcs, rib_req, rib_rdy, gnt, rsp;
  logic [3:0]    rib_mask;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, who is due next, who is being held.
  int m_pending, m_owner, m_next, m_lock, m_lock_id;
  int exp_id;
  logic exp_req, exp_rdy;
  logic [M-1:0] exp_gnt, exp_rsp;

  rib_master_arb #(.masters(M)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ribm_addr(addr), .i_ribm_wrcs(wrcs), .i_ribm_mask(mask), .i_ribm_wdata(wdata),
    .o_ribm_rdata(ribm_rdata), .i_ribm_req(req), .o_ribm_gnt(ribm_gnt),
    .o_ribm_rsp(ribm_rsp), .i_ribm_rdy(rdy),
    .o_rib_addr(rib_addr), .o_rib_wrcs(rib_wrcs), .o_rib_mask(rib_mask),
    .o_rib_wdata(rib_wdata), .i_rib_rdata(rdata), .o_rib_req(rib_req),
    .i_rib_gnt(gnt), .i_rib_rsp(rsp), .o_rib_rdy(rib_rdy)
  );

  always #5 clk = ~clk;

  function automatic void model_eval();
    bit free;
    exp_id = 0;
    if (m_lock != 0) exp_id = m_lock_id;
    else begin
      for (int off = M - 1; off >= 0; off--)
        if (req[(m_next + off) % M]) exp_id = (m_next + off) % M;
    end
    free    = (m_pending == 0) || (rsp && rdy[m_owner]);
    exp_req = !rst && (req != 0) && free;
    exp_gnt = (exp_req && gnt) ? M'(1 << exp_id) : '0;
    exp_rsp = (!rst && m_pending != 0 && rsp) ? M'(1 << m_owner) : '0;
    exp_rdy = !rst && m_pending != 0 && rdy[m_owner];
  endfunction

  function automatic void model_update();
    if (rst) begin
      m_pending = 0; m_owner = 0; m_next = 0; m_lock = 0; m_lock_id = 0;
    end else if (exp_req && gnt) begin
      m_pending = 1; m_owner = exp_id; m_next = (exp_id + 1) % M; m_lock = 0;
    end else begin
      if (exp_req) begin m_lock = 1; m_lock_id = exp_id; end
      if (m_pending != 0 && rsp && rdy[m_owner]) m_pending = 0;
    end
  endfunction

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    req = '0; gnt = 1'b0; rsp = 1'b0; rdy = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    sample();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; gnt = 1'b1; rsp = 1'b1; rdy = 2'b11;
    sample();
    n_checks++;
    if (rib_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", rib_req); end
    n_checks++;
    if (ribm_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", ribm_gnt); end
    n_checks++;
    if (ribm_rsp !== 2'b00 || rib_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp: got rsp=%b rdy=%b want 00/0", ribm_rsp, rib_rdy);
    end
    advance();
    rst = 1'b0;
    set_idle();
  endtask

  task automatic test_single_read();
    do_reset();
    req = 2'b01; addr[31:0] = 32'h0200_0010; wrcs = 2'b00; gnt = 1'b1;
    sample();
    n_checks++;
    if (ribm_gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b want 01", ribm_gnt); end
    n_checks++;
    if (rib_addr !== 32'h0200_0010 || rib_wrcs !== 1'b0) begin
      n_fail++; $display("FAIL single_addr: got %h/%b want 02000010/0", rib_addr, rib_wrcs);
    end
    advance();
    req = 2'b00; gnt = 1'b0; rsp = 1'b1; rdata = 32'h1234_5678; rdy = 2'b01;
    sample();
    n_checks++;
    if (ribm_rsp !== 2'b01) begin n_fail++; $display("FAIL single_rsp: got %b want 01", ribm_rsp); end
    n_checks++;
    if (ribm_rdata[31:0] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL single_rdata: got %h want 12345678", ribm_rdata[31:0]);
    end
    advance();
    set_idle();
    sample();
    n_checks++;
    if (ribm_rsp !== 2'b00) begin n_fail++; $display("FAIL single_idle_rsp: got %b want 00", ribm_rsp); end
    advance();
  endtask

  task automatic test_fairness();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req = 2'b11; gnt = 1'b1; rdy = 2'b11; rsp = (c > 0);
      sample();
      n_checks++;
      if (ribm_gnt !== 2'(1 << (c % 2))) begin
        n_fail++; $display("FAIL fair_gnt[%0d]: got %b want %b", c, ribm_gnt, 2'(1 << (c % 2)));
      end
      if (c > 0) begin
        n_checks++;
        if (ribm_rsp !== 2'(1 << ((c - 1) % 2))) begin
          n_fail++; $display("FAIL fair_rsp[%0d]: got %b want %b", c, ribm_rsp, 2'(1 << ((c - 1) % 2)));
        end
      end
      advance();
    end
    req = 2'b00; rsp = 1'b1;
    advance();
    set_idle();
  endtask

  task automatic test_lock();
    do_reset();
    addr[63:32] = 32'h1000_0004; addr[31:0] = 32'hDEAD_0000;
    for (int c = 1; c <= 3; c++) begin
      req = (c >= 2) ? 2'b11 : 2'b10; gnt = 1'b0;
      sample();
      n_checks++;
      if (rib_req !== 1'b1 || rib_addr !== 32'h1000_0004 || ribm_gnt !== 2'b00) begin
        n_fail++; $display("FAIL lock_hold[%0d]: got req=%b addr=%h gnt=%b want 1/10000004/00", c, rib_req, rib_addr, ribm_gnt);
      end
      advance();
    end
    gnt = 1'b1;
    sample();
    n_checks++;
    if (ribm_gnt !== 2'b10) begin n_fail++; $display("FAIL lock_gnt: got %b want 10", ribm_gnt); end
    advance();
    req = 2'b01; rsp = 1'b1; rdy = 2'b11;
    sample();
    n_checks++;
    if (ribm_gnt !== 2'b01 || ribm_rsp !== 2'b10) begin
      n_fail++; $display("FAIL lock_next: got gnt=%b rsp=%b want 01/10", ribm_gnt, ribm_rsp);
    end
    advance();
    req = 2'b00; gnt = 1'b0;
    advance();
    set_idle();
  endtask

  task automatic test_response_stall();
    do_reset();
    req = 2'b01; gnt = 1'b1;
    sample();
    advance();
    for (int c = 0; c < 2; c++) begin
      req = 2'b10; rsp = 1'b1; rdy = 2'b00;
      sample();
      n_checks++;
      if (rib_req !== 1'b0 || rib_rdy !== 1'b0 || ribm_gnt !== 2'b00) begin
        n_fail++; $display("FAIL stall[%0d]: got req=%b rdy=%b gnt=%b want 0/0/00", c, rib_req, rib_rdy, ribm_gnt);
      end
      advance();
    end
    rdy = 2'b01;
    sample();
    n_checks++;
    if (ribm_gnt !== 2'b10 || rib_rdy !== 1'b1 || ribm_rsp !== 2'b01) begin
      n_fail++; $display("FAIL stall_release: got gnt=%b rdy=%b rsp=%b want 10/1/01", ribm_gnt, rib_rdy, ribm_rsp);
    end
    advance();
    req = 2'b00; rdy = 2'b10;
    advance();
    set_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 2'b01; gnt = 1'b1;
    sample();
    advance();
    req = 2'b10; rsp = 1'b1; rdy = 2'b01;
    sample();
    n_checks++;
    if (ribm_gnt !== 2'b10 || ribm_rsp !== 2'b01) begin
      n_fail++; $display("FAIL b2b_switch: got gnt=%b rsp=%b want 10/01", ribm_gnt, ribm_rsp);
    end
    advance();
    req = 2'b00; gnt = 1'b0; rdy = 2'b10;
    sample();
    n_checks++;
    if (ribm_rsp !== 2'b10) begin n_fail++; $display("FAIL b2b_new_owner: got %b want 10", ribm_rsp); end
    advance();
    sample();
    n_checks++;
    if (ribm_rsp !== 2'b00) begin n_fail++; $display("FAIL b2b_drop: got %b want 00", ribm_rsp); end
    advance();
    set_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b01; gnt = 1'b1;
    sample();
    advance();
    rst = 1'b1; set_idle();
    sample();
    advance();
    rst = 1'b0; rsp = 1'b1; rdy = 2'b11;
    sample();
    n_checks++;
    if (ribm_rsp !== 2'b00 || rib_rdy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_rsp: got rsp=%b rdy=%b want 00/0", ribm_rsp, rib_rdy);
    end
    advance();
    req = 2'b11; gnt = 1'b1; rsp = 1'b0;
    sample();
    n_checks++;
    if (ribm_gnt !== 2'b01) begin n_fail++; $display("FAIL rstmid_first: got %b want 01", ribm_gnt); end
    advance();
    req = 2'b00; rsp = 1'b1; gnt = 1'b0;
    advance();
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 59) == 0);
      req   = M'($urandom);
      gnt   = 1'($urandom);
      rsp   = 1'($urandom);
      rdy   = M'($urandom);
      addr  = {$urandom, $urandom};
      wdata = {$urandom, $urandom};
      wrcs  = M'($urandom);
      mask  = (4*M)'($urandom);
      rdata = $urandom;
      sample();
      n_checks++;
      if (rib_req !== exp_req || ribm_gnt !== exp_gnt) begin
        n_fail++; $display("FAIL rand_req[%0d]: got req=%b gnt=%b want %b/%b", c, rib_req, ribm_gnt, exp_req, exp_gnt);
      end
      n_checks++;
      if (ribm_rsp !== exp_rsp || rib_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL rand_rsp[%0d]: got rsp=%b rdy=%b want %b/%b", c, ribm_rsp, rib_rdy, exp_rsp, exp_rdy);
      end
      if (exp_req) begin
        n_checks++;
        if (rib_addr !== addr[32*exp_id +: 32] || rib_wdata !== wdata[32*exp_id +: 32] ||
            rib_wrcs !== wrcs[exp_id] || rib_mask !== mask[4*exp_id +: 4]) begin
          n_fail++; $display("FAIL rand_mux[%0d]: got addr=%h want %h (master %0d)", c, rib_addr, addr[32*exp_id +: 32], exp_id);
        end
      end
      n_checks++;
      if (ribm_rdata !== {M{rdata}}) begin
        n_fail++; $display("FAIL rand_rdata[%0d]: got %h want %h", c, ribm_rdata, {M{rdata}});
      end
      advance();
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    addr = '0; wdata = '0; wrcs = '0; mask = '0; rdata = '0;
    set_idle();
    m_pending = 0; m_owner = 0; m_next = 0; m_lock = 0; m_lock_id = 0;
    #1;
    test_reset();
    test_single_read();
    test_fairness();
    test_lock();
    test_response_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
